// File: rtl/reg_scoreboard.sv
// reg_scoreboard: counted register scoreboard that stalls decode on in-flight writes
//   clk, rst                      clock, asynchronous active-high reset
//   src1, src2, Two_src           decode source registers, src2 valid flag
//   Dest, WB_EN                   decode destination and issue strobe
//   writeBackEn, Dest_wb          writeback strobe and register
//   hazard                        combinational stall to decode
//   pending_any                   registered: any register has a write in flight
//   stall_count                   registered saturating count of stalled cycles
//   ovf_err, unf_err              sticky counter overflow / underflow flags
module reg_scoreboard #(
   parameter int CNT_W     = 2,
   parameter int WB_BYPASS = 1,
   parameter int STAT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        src1,
   input  logic [3:0]        src2,
   input  logic              Two_src,
   input  logic [3:0]        Dest,
   input  logic              WB_EN,
   input  logic              writeBackEn,
   input  logic [3:0]        Dest_wb,
   output logic              hazard,
   output logic              pending_any,
   output logic [STAT_W-1:0] stall_count,
   output logic              ovf_err,
   output logic              unf_err
);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
   logic [CNT_W-1:0] cnt     [16];
   logic [CNT_W-1:0] cnt_nxt [16];
   logic [15:0]      busy;
   logic             ovf_hit, unf_hit, pend_nxt;
   always_comb begin
      busy     = '0;
      ovf_hit  = 1'b0;
      unf_hit  = 1'b0;
      pend_nxt = 1'b0;
      for (int r = 0; r < 16; r++) begin
         cnt_nxt[r] = cnt[r];
         // a last write retiring now is visible through the write-through register file
         busy[r] = cnt[r] != '0 && !(WB_BYPASS != 0 && writeBackEn && Dest_wb == 4'(r) && cnt[r] == CONE);
         // issue and retire on the same register cancel, so neither saturation check applies
         if (WB_EN && Dest == 4'(r) && !(writeBackEn && Dest_wb == 4'(r))) begin
            if (cnt[r] == CMAX) ovf_hit = 1'b1;
            else cnt_nxt[r] = cnt[r] + CONE;
         end
         if (writeBackEn && Dest_wb == 4'(r) && !(WB_EN && Dest == 4'(r))) begin
            if (cnt[r] == '0) unf_hit = 1'b1;
            else cnt_nxt[r] = cnt[r] - CONE;
         end
         pend_nxt = pend_nxt | (cnt_nxt[r] != '0);
      end
   end
   assign hazard = busy[src1] | (Two_src & busy[src2]);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < 16; r++) cnt[r] <= '0;
         pending_any <= 1'b0;
         stall_count <= '0;
         ovf_err     <= 1'b0;
         unf_err     <= 1'b0;
      end else begin
         for (int r = 0; r < 16; r++) cnt[r] <= cnt_nxt[r];
         pending_any <= pend_nxt;
         stall_count <= (hazard && stall_count != '1) ? stall_count + 1'b1 : stall_count;
         ovf_err     <= ovf_err | ovf_hit;
         unf_err     <= unf_err | unf_hit;
      end
   end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard responder for the decode stage. Tracks which architectural registers have a write in flight between decode issue and writeback, and drives the `hazard` stall back to decode.
- Sits beside ID_stage. Consumes its `src1`/`src2`/`Two_src`/`Dest`/`WB_EN` outputs and the writeback-stage `writeBackEn`/`Dest_wb`.
- Replaces the combinational per-stage destination compare with a counted scoreboard, so it is independent of pipeline depth.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1.
- WB_BYPASS, 1, 1 = a register retiring this cycle with count 1 does not stall (register file is write-through); 0 = stall until the counter is actually zero.
- STAT_W, 16, width of the saturating stall-cycle statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- src1  input  4  first source register of instruction in decode.
- src2  input  4  second source register of instruction in decode.
- Two_src  input  1  1 = src2 is a real operand.
- Dest  input  4  destination register of instruction in decode.
- WB_EN  input  1  decode issues a register-writing instruction this cycle (already gated by hazard/condition).
- writeBackEn  input  1  writeback stage writes the register file this cycle.
- Dest_wb  input  4  register written at writeback.
- hazard  output  1  stall decode (combinational).
- pending_any  output  1  registered; 1 if any counter is nonzero.
- stall_count  output  STAT_W  registered count of cycles with hazard=1; saturates at all-ones.
- ovf_err  output  1  sticky: issue attempted on a saturated counter.
- unf_err  output  1  sticky: retire on a zero counter.

Behaviour:
- State: cnt[0..15], each CNT_W bits, plus stall_count, ovf_err, unf_err and pending_any.
- Reset (async, any time incl. mid-operation): all cnt=0, stall_count=0, ovf_err=0, unf_err=0, pending_any=0. Hence hazard=0 while rst is high.
- busy(r):
  - cnt[r]!=0, and
  - not (WB_BYPASS=1 and writeBackEn and Dest_wb==r and cnt[r]==1).
- hazard = busy(src1) | (Two_src & busy(src2)). Zero-cycle path; no registers between inputs and hazard.
- Issue: when WB_EN=1 at a clock edge, cnt[Dest] += 1.
- Retire: when writeBackEn=1 at a clock edge, cnt[Dest_wb] -= 1.
- Simultaneous issue and retire on the same register: net zero; cnt is unchanged and no error is raised, even if cnt is at max or at 0.
- Simultaneous issue and retire on different registers: both applied independently.
- Saturation:
  - Issue with cnt at 2^CNT_W-1 (and no same-register retire): cnt holds, ovf_err<=1.
  - Retire with cnt=0 (and no same-register issue): cnt holds at 0, unf_err<=1.
  - Error flags clear only on rst.
- An instruction may be its own source (src1==Dest). The hazard check uses the pre-issue cnt. The scoreboard never self-stalls an instruction on its own Dest.
- stall_count increments every edge where hazard=1, stopping at all-ones.
- pending_any reflects post-update counters, one cycle after the edge that changes them.
- Decode gates WB_EN with hazard, so a stalled instruction is not counted; the block does not re-check this.

Test Plan:
- Reset and idle: assert rst mid-run with cnt[3]=2 -> all cnt=0, hazard=0, pending_any=0, stall_count=0 immediately, without waiting for a clock.
- RAW stall:
  - Issue Dest=5 (WB_EN=1); next cycle src1=5 -> hazard=1 and stall_count increments each cycle.
  - Then writeBackEn=1, Dest_wb=5: with WB_BYPASS=1, hazard=0 in that same cycle; with WB_BYPASS=0, hazard=0 the cycle after.
- Two_src gating: cnt[7]=1, src1=2, src2=7 -> hazard=0 with Two_src=0 and hazard=1 with Two_src=1.
- Multiple in flight: three issues to R4 with CNT_W=2 -> cnt=3. A fourth issue -> cnt stays 3 and ovf_err=1. Three retires -> hazard on R4 clears, pending_any=0 one cycle later.
- Simultaneous same-register issue and retire: cnt[9]=1, WB_EN=1, Dest=9, writeBackEn=1, Dest_wb=9 -> cnt[9]=1 after the edge, no error.
- Underflow: retire Dest_wb=12 with cnt[12]=0 -> unf_err=1, cnt stays 0. Sticky through 10 further cycles; cleared only by rst.
